// File: rtl/pool_map_collector.sv
// Collects the pooled-bit stream into two ping-pong row-organised banks and
// drains each completed bank one row per valid/ready beat.
module pool_map_collector #(
   parameter int OUT_W = 13,
   parameter int OUT_H = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pool_in,
   input  logic             pool_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             frame_drop,
   output logic             overflow
);

   // state  | meaning
   // R_IDLE | no beat presented; waiting for full[rbank]
   // R_SEND | row rrow of bank rbank presented on out_data

   localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int YW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);

   typedef enum logic {R_IDLE, R_SEND} rstate_t;

   logic [OUT_W-1:0] mem [2][OUT_H];
   logic [XW-1:0]    wx;
   logic [YW-1:0]    wy;
   logic             wbank;
   logic             discard;
   logic [1:0]       full;
   logic             rbank;
   logic [YW-1:0]    rrow;
   rstate_t          state, state_nxt;

   logic xfer, release_b, frame_start, frame_end, bank_free, drop_now, keep;

   // A bank released by the reader on this edge is free for a frame starting now.
   always_comb begin
      xfer        = out_valid && out_ready;
      release_b   = (state == R_SEND) && xfer && (rrow == Y_LAST);
      frame_start = pool_valid && (wx == '0) && (wy == '0);
      frame_end   = pool_valid && (wx == X_LAST) && (wy == Y_LAST);
      bank_free   = !full[wbank] || (release_b && (rbank == wbank));
      drop_now    = frame_start && !bank_free;
      keep        = frame_start ? bank_free : !discard;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wx         <= '0;
         wy         <= '0;
         wbank      <= 1'b0;
         discard    <= 1'b0;
         frame_drop <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_drop <= drop_now;
         if (drop_now)
            overflow <= 1'b1;
         if (pool_valid) begin
            if (frame_start)
               discard <= !bank_free;
            if (wx == X_LAST) begin
               wx <= '0;
               wy <= (wy == Y_LAST) ? '0 : wy + YW'(1);
            end else begin
               wx <= wx + XW'(1);
            end
            if (frame_end && keep)
               wbank <= ~wbank;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pool_valid && keep)
         mem[wbank][wy][wx] <= pool_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 2'b00;
      end else begin
         if (release_b)
            full[rbank] <= 1'b0;
         if (frame_end && keep)
            full[wbank] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= R_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         R_IDLE:  if (full[rbank]) state_nxt = R_SEND;
         R_SEND:  if (release_b)   state_nxt = R_IDLE;
         default: state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == R_SEND);
      out_last  = (state == R_SEND) && (rrow == Y_LAST);
   end

   // Next row is fetched on the transfer edge so beats stream one per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rbank    <= 1'b0;
         rrow     <= '0;
         out_data <= '0;
      end else begin
         case (state)
            R_IDLE: begin
               if (full[rbank]) begin
                  rrow     <= '0;
                  out_data <= mem[rbank][0];
               end
            end
            R_SEND: begin
               if (xfer) begin
                  if (rrow == Y_LAST) begin
                     rbank <= ~rbank;
                  end else begin
                     rrow     <= rrow + YW'(1);
                     out_data <= mem[rbank][rrow + YW'(1)];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pool_map_collector.sv
// Bench for pool_map_collector: frame-level reference model (queue of rows
// expected downstream) plus a beat monitor that records transfers and stalls.
module tb_pool_map_collector;
   localparam int W = 13;
   localparam int H = 13;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         pool_in = 1'b0;
   logic         pool_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_last;
   logic         frame_drop;
   logic         overflow;

   pool_map_collector #(.OUT_W(W), .OUT_H(H)) dut (
      .clk(clk), .rst(rst), .pool_in(pool_in), .pool_valid(pool_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .frame_drop(frame_drop), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [W:0]   rx[$];
   int           rx_cyc[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] fr[H];
   int           drop_cnt = 0;
   int           drop_cyc = -1;
   int           stall_viol = 0;
   int           start_cyc = 0;
   int           end_cyc = 0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;
   logic         prev_last = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Beat monitor: records transfers, drop pulses and stall stability.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
            stall_viol++;
         if (out_valid && out_ready) begin
            rx.push_back({out_last, out_data});
            rx_cyc.push_back(cyc);
         end
         if (frame_drop === 1'b1) begin
            drop_cnt++;
            drop_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic clear_rec();
      rx.delete();
      rx_cyc.delete();
      exp_q.delete();
      drop_cnt   = 0;
      drop_cyc   = -1;
      stall_viol = 0;
   endtask

   task automatic rand_frame();
      for (int y = 0; y < H; y++) fr[y] = W'($urandom);
   endtask

   task automatic expect_frame();
      for (int y = 0; y < H; y++) exp_q.push_back(fr[y]);
   endtask

   task automatic send_frame(input int gap);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            pool_in    = fr[y][x];
            pool_valid = 1'b1;
            @(posedge clk); #1;
            if (x == 0 && y == 0) start_cyc = cyc;
            pool_valid = 1'b0;
            pool_in    = 1'b0;
            if (!(x == W-1 && y == H-1))
               repeat (gap) begin @(posedge clk); #1; end
         end
      end
      end_cyc = cyc;
   endtask

   task automatic test_reset();
      rst = 1'b1; pool_valid = 1'b0; out_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", out_last); end
      checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", frame_drop); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [W-1:0] row0, row1;
      row0 = 13'b1010101010101;
      row1 = 13'b0101010101010;
      clear_rec();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) fr[y][x] = ((x + y) % 2 == 0);
      expect_frame();
      out_ready = 1'b1;
      send_frame(1);
      for (int t = 0; t < 100 && rx.size() < 13; t++) begin @(posedge clk); #1; end
      checks++; if (rx.size() != exp_q.size()) begin errors++; $display("FAIL single_count got %0d exp %0d", rx.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         checks++; if (rx[i] !== {(i % H) == H-1, exp_q[i]}) begin errors++; $display("FAIL single_beat%0d got %h exp %h", i, rx[i], {(i % H) == H-1, exp_q[i]}); end
      end
      if (rx.size() >= 13) begin
         checks++; if (rx[0][W-1:0] !== row0) begin errors++; $display("FAIL single_row0 got %b exp %b", rx[0][W-1:0], row0); end
         checks++; if (rx[1][W-1:0] !== row1) begin errors++; $display("FAIL single_row1 got %b exp %b", rx[1][W-1:0], row1); end
         checks++; if (rx_cyc[0] != end_cyc + 1) begin errors++; $display("FAIL single_first_cycle got %0d exp %0d", rx_cyc[0], end_cyc + 1); end
         checks++; if (rx_cyc[12] != rx_cyc[0] + 12) begin errors++; $display("FAIL single_back_to_back got %0d exp %0d", rx_cyc[12], rx_cyc[0] + 12); end
      end
      checks++; if (drop_cnt != 0) begin errors++; $display("FAIL single_drop got %0d exp 0", drop_cnt); end
   endtask

   task automatic test_backpressure();
      clear_rec();
      rand_frame();
      expect_frame();
      out_ready = 1'b0;
      send_frame(0);
      for (int k = 0; k < 400 && rx.size() < 13; k++) begin
         out_ready = (k % 4 == 0) || (k % 4 == 3);
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      checks++; if (rx.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", rx.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         checks++; if (rx[i] !== {(i % H) == H-1, exp_q[i]}) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", i, rx[i], {(i % H) == H-1, exp_q[i]}); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got %0d exp 0", stall_viol); end
   endtask

   task automatic test_ping_pong();
      int e1;
      clear_rec();
      out_ready = 1'b1;
      for (int y = 0; y < H; y++) fr[y] = '1;
      expect_frame();
      send_frame(0);
      e1 = end_cyc;
      for (int y = 0; y < H; y++) fr[y] = '0;
      expect_frame();
      send_frame(0);
      for (int t = 0; t < 100 && rx.size() < 26; t++) begin @(posedge clk); #1; end
      checks++; if (rx.size() != exp_q.size()) begin errors++; $display("FAIL pp_count got %0d exp %0d", rx.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         checks++; if (rx[i] !== {(i % H) == H-1, exp_q[i]}) begin errors++; $display("FAIL pp_beat%0d got %h exp %h", i, rx[i], {(i % H) == H-1, exp_q[i]}); end
      end
      if (rx.size() >= 26) begin
         checks++; if (rx_cyc[0] != e1 + 1) begin errors++; $display("FAIL pp_first1 got %0d exp %0d", rx_cyc[0], e1 + 1); end
         checks++; if (rx_cyc[13] != end_cyc + 1) begin errors++; $display("FAIL pp_first2 got %0d exp %0d", rx_cyc[13], end_cyc + 1); end
      end
      checks++; if (drop_cnt != 0) begin errors++; $display("FAIL pp_drop got %0d exp 0", drop_cnt); end
   endtask

   task automatic test_same_cycle_release();
      clear_rec();
      out_ready = 1'b0;
      rand_frame(); expect_frame(); send_frame(0);
      rand_frame(); expect_frame(); send_frame(0);
      repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      repeat (12) begin @(posedge clk); #1; end
      rand_frame(); expect_frame(); send_frame(0);
      for (int t = 0; t < 200 && rx.size() < 39; t++) begin @(posedge clk); #1; end
      checks++; if (rx.size() != exp_q.size()) begin errors++; $display("FAIL scr_count got %0d exp %0d", rx.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         checks++; if (rx[i] !== {(i % H) == H-1, exp_q[i]}) begin errors++; $display("FAIL scr_beat%0d got %h exp %h", i, rx[i], {(i % H) == H-1, exp_q[i]}); end
      end
      if (rx.size() >= 13) begin
         checks++; if (rx_cyc[12] != start_cyc - 1) begin errors++; $display("FAIL scr_alignment got %0d exp %0d", rx_cyc[12], start_cyc - 1); end
      end
      checks++; if (drop_cnt != 0) begin errors++; $display("FAIL scr_drop got %0d exp 0", drop_cnt); end
   endtask

   task automatic test_random();
      bit done;
      done = 1'b0;
      clear_rec();
      fork
         begin
            for (int f = 0; f < 4; f++) begin
               rand_frame();
               expect_frame();
               send_frame($urandom_range(0, 2));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
         end
      join
      out_ready = 1'b1;
      for (int t = 0; t < 200 && rx.size() < 52; t++) begin @(posedge clk); #1; end
      checks++; if (rx.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", rx.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         checks++; if (rx[i] !== {(i % H) == H-1, exp_q[i]}) begin errors++; $display("FAIL rnd_beat%0d got %h exp %h", i, rx[i], {(i % H) == H-1, exp_q[i]}); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL rnd_stall_stable got %0d exp 0", stall_viol); end
      checks++; if (drop_cnt != 0) begin errors++; $display("FAIL rnd_drop got %0d exp 0", drop_cnt); end
   endtask

   task automatic test_overflow();
      int f3_start;
      clear_rec();
      out_ready = 1'b0;
      rand_frame(); expect_frame(); send_frame(0);
      rand_frame(); expect_frame(); send_frame(0);
      rand_frame(); send_frame(0);
      f3_start = start_cyc;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (drop_cnt != 1) begin errors++; $display("FAIL ovf_drop_count got %0d exp 1", drop_cnt); end
      checks++; if (drop_cyc != f3_start) begin errors++; $display("FAIL ovf_drop_cycle got %0d exp %0d", drop_cyc, f3_start); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
      out_ready = 1'b1;
      for (int t = 0; t < 200 && rx.size() < 26; t++) begin @(posedge clk); #1; end
      repeat (40) begin @(posedge clk); #1; end
      checks++; if (rx.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d exp %0d", rx.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         checks++; if (rx[i] !== {(i % H) == H-1, exp_q[i]}) begin errors++; $display("FAIL ovf_beat%0d got %h exp %h", i, rx[i], {(i % H) == H-1, exp_q[i]}); end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_still_set got %b exp 1", overflow); end
   endtask

   task automatic test_reset_mid_drain();
      clear_rec();
      out_ready = 1'b0;
      rand_frame();
      send_frame(0);
      out_ready = 1'b1;
      for (int t = 0; t < 100 && rx.size() < 4; t++) begin @(posedge clk); #1; end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmd_mid_valid got %b exp 1", out_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmd_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL rmd_data got %h exp 0", out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rmd_last got %b exp 0", out_last); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmd_ovf got %b exp 0", overflow); end
      checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL rmd_drop got %b exp 0", frame_drop); end
      rst = 1'b0;
      @(posedge clk); #1;
      clear_rec();
      rand_frame(); expect_frame();
      send_frame(1);
      for (int t = 0; t < 100 && rx.size() < 13; t++) begin @(posedge clk); #1; end
      checks++; if (rx.size() != exp_q.size()) begin errors++; $display("FAIL rmd_count got %0d exp %0d", rx.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         checks++; if (rx[i] !== {(i % H) == H-1, exp_q[i]}) begin errors++; $display("FAIL rmd_beat%0d got %h exp %h", i, rx[i], {(i % H) == H-1, exp_q[i]}); end
      end
      if (rx.size() >= 1) begin
         checks++; if (rx_cyc[0] != end_cyc + 1) begin errors++; $display("FAIL rmd_first_cycle got %0d exp %0d", rx_cyc[0], end_cyc + 1); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_ping_pong();
      test_same_cycle_release();
      test_random();
      test_overflow();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pool_map_collector.md
Name: pool_map_collector

Overview:
- Receives the sparse pooled-bit stream produced after the 2x2 max-pooling stage: one bit per pool_valid strobe, raster order, OUT_W x OUT_H per frame (13x13 for MNIST).
- Assembles each frame into one of two ping-pong banks.
- Drains a completed bank to the dense layer one row per beat over a valid/ready handshake.
- The pooling stage cannot stall, so the block has no input ready. The banks absorb output back-pressure, and any frame that cannot be stored is dropped and flagged.

Parameters:
- OUT_W, 13, pooled map width; bits per output beat.
- OUT_H, 13, pooled map height; beats per frame.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- pool_in, input, 1, pooled pixel value.
- pool_valid, input, 1, pool_in valid this cycle; may arrive on any cycle, with arbitrary gaps.
- out_data, output, OUT_W, one map row; bit i = column i.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts beat.
- out_last, output, 1, high with row OUT_H-1.
- frame_drop, output, 1, one-cycle pulse when an incoming frame is discarded.
- overflow, output, 1, sticky; set on any drop; cleared only by rst.

Behaviour:
- Reset (rst=1 at an edge): all outputs 0. Write counters wx, wy and bank select wbank reset to 0. Both bank full flags clear. Read bank rbank = 0, reader in R_IDLE. Bank contents are don't-care. Reset mid-fill or mid-drain abandons the frame with no partial output.
- Writer, on each pool_valid cycle:
  - Store pool_in at bank[wbank][wy][wx] unless the frame is marked discard.
  - wx increments. At wx = OUT_W-1, wx returns to 0 and wy increments. At wy = OUT_H-1 with wx = OUT_W-1, both counters return to 0.
  - Counters advance even for discarded frames, so frame alignment is kept.
- Frame-start check, on the sample with wx = 0 and wy = 0:
  - If full[wbank] = 1, the whole frame is discarded. frame_drop pulses the next cycle and overflow is set.
  - A bank released by the reader on the same cycle counts as free: the release bypasses into the check.
- Frame end, on the final sample (wx = OUT_W-1, wy = OUT_H-1):
  - If the frame was not discarded, full[wbank] is set on that edge and wbank toggles.
  - If the frame was discarded, wbank does not toggle.
- Reader FSM:
  - R_IDLE: if full[rbank], load row 0 into out_data, set out_valid, row counter = 0, and go to R_SEND. The first out_valid therefore appears one edge after the edge that sets full.
  - R_SEND:
    - A beat transfers on a cycle with out_valid && out_ready.
    - On a transfer of a row below OUT_H-1, the next row loads on the same edge, so back-to-back beats run at one per cycle when out_ready is held high.
    - out_last = (row counter == OUT_H-1) && out_valid.
    - While out_ready = 0, out_data, out_last and out_valid stay stable.
    - On the transfer of the last row: clear full[rbank], toggle rbank, drop out_valid, and return to R_IDLE. If the other bank is already full, the reader re-enters R_SEND via R_IDLE one cycle later, leaving exactly one idle cycle between frames.
- out_valid never deasserts without a transfer, except on rst.
- Simultaneous events: a write into bank A while bank B drains is legal and the intended steady state. Writer and reader never touch the same bank, guaranteed by the full flags.
- Storage: 2*OUT_H*OUT_W flops or distributed RAM. Row readout is a full-row parallel read.

Test Plan:
- Single frame, out_ready=1, pool_valid every 2nd cycle, checkerboard data: 169 samples -> 13 beats on consecutive cycles starting one edge after the full flag sets. Row 0 = 13'b1010101010101, row 1 = 13'b0101010101010, and so on. out_last only on beat 13; no frame_drop.
- Back-pressure: out_ready toggles 1,0,0,1 repeating during drain -> each row held stable while stalled; all 13 rows delivered exactly once, in order.
- Ping-pong: two frames back-to-back (all-ones then all-zeros), out_ready=1 -> frame 1 drains from bank 0 while frame 2 fills bank 1. Output is 13 beats of 13'h1FFF, then, after the second frame completes, 13 beats of 13'h0000.
- Overflow: out_ready=0 throughout, three frames sent -> frames 1 and 2 stored; frame 3 discarded. frame_drop pulses once, one cycle after frame 3's first sample; overflow stays 1. After out_ready is raised, exactly 26 beats come out (frames 1 and 2).
- Same-cycle release: time frame 3's first sample to coincide with the last-row transfer of frame 1 -> frame 3 is accepted (no drop) and drains after frame 2.
- Reset mid-drain: assert rst during beat 5 of a frame -> next cycle all outputs are 0. A fresh frame afterwards drains correctly starting from row 0 of bank 0.
